game_status_display: RTL and testbench
======================================

Name: game_status_display

Overview:
- Downstream display stage of the matchstick game.
- Consumes the game core's live state: turn number, remaining sum (0..255) and the correctness flag.
- Drives a 4-digit multiplexed seven-segment panel:
  - digit 3 shows the turn;
  - digits 2..0 show the sum in decimal;
  - an invalid move is flagged on digit 3 with "E".
- Binary-to-BCD conversion is sequential (shift-add-3), so the block needs no wide combinational divider.

Parameters:
- SCAN_DIV, 50000: clk cycles each digit is held before the scan advances; minimum 2.
- BLINK_DIV, 12500000: clk cycles per half-period of the error blink; minimum 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active low.
- turn  input  4  current player number from the game core (1 or 2 in normal play).
- sum  input  8  remaining matchsticks, unsigned.
- correctness  input  1  1 = last move legal; 0 = illegal move pending.
- grounds  output  4  one-hot digit enable; grounds[i]=1 enables digit i; digit 3 is leftmost.
- display  output  7  segment drive, active high, bit order {g,f,e,d,c,b,a}.

Behaviour:
- Reset: while rst_n=0 at a clk edge, the block clears:
  - scan counter = 0, digit index = 0 (grounds=4'b0001 after reset);
  - blink counter = 0, blink phase = on;
  - BCD register = 000, captured sum = 0;
  - converter FSM = IDLE.
  - display is all segments off (7'b0000000) during reset and on the first cycle after it.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1.
  - On terminal count, digit index increments mod 4 (0,1,2,3,0...).
  - grounds is registered and changes on the same edge as the index.
  - display is registered from the new index, so segments and grounds change on the same edge with no ghosting.
- Converter FSM:
  - IDLE:
    - If sum != captured sum, capture sum, clear the 12-bit BCD scratch and the iteration count, go to SHIFT.
    - Capture also happens on the first IDLE cycle after reset.
  - SHIFT:
    - Each cycle, add 3 to every scratch nibble >= 5, then shift {scratch, operand} left by 1.
    - After the 8th shift go to DONE.
  - DONE: copy scratch into the BCD register in one cycle, go to IDLE.
  - Latency: the BCD register is updated 10 clk cycles after sum changes (capture + 8 shifts + DONE).
  - sum changing mid-conversion: the conversion finishes with the old captured value, then IDLE recaptures. There are no partial updates.
- Digit content:
  - Digit 0: units.
  - Digit 1: tens; blank if hundreds=0 and tens=0.
  - Digit 2: hundreds; blank if 0.
  - sum=0 shows a single "0" on digit 0.
  - Digit 3: hex glyph of turn (0-9, A-F).
  - When correctness=0, digit 3 shows "E" (7'b1111001) instead.
- Glyphs 0-9 use standard patterns. Blank = 7'b0000000.
- Simultaneous sum change and reset: reset wins.

Optional Feature:
- ERR_BLINK_EN defined:
  - While correctness=0, digit 3 ("E") toggles between visible and blank every BLINK_DIV cycles.
  - The blink counter and phase reset to 0/on when correctness returns to 1.
- ERR_BLINK_EN undefined:
  - "E" is steady.
  - The blink counter logic is not instantiated.

Decomposition:
- Shared package game_pkg holds:
  - seven-segment glyph constants (SEG_0..SEG_9, SEG_A..SEG_F, SEG_E_ERR, SEG_BLANK);
  - the digit-index width constant;
  - the converter state typedef (IDLE, SHIFT, DONE).
- One natural sub-module, bin8_to_bcd3_seq: the converter FSM with start/done handshake. The top handles scan, blink and glyph mux.

Test Plan:
- Reset with SCAN_DIV=4: hold rst_n=0 for 3 cycles -> grounds=0001, display=0000000. After release, grounds steps 0001->0010->0100->1000->0001 every 4 cycles.
- sum=100, turn=1, correctness=1 -> after 10 cycles, scan shows:
  - digit0 "0" (0111111), digit1 "0", digit2 "1" (0000110), digit3 "1".
- sum=7 -> digit0 "7" (0000111), digits 1 and 2 blank. sum=0 -> digit0 "0", others blank.
- sum changes 100->93 at cycle 3 of a conversion -> BCD register first shows 100 (exactly at 10 cycles from the first change), then 093 at 10 cycles after the recapture. Digit 2 blank for 93.
- correctness=0, turn=2 -> digit 3 shows 1111001.
  - With ERR_BLINK_EN and BLINK_DIV=8: digit 3 alternates 1111001/0000000 every 8 cycles.
  - After correctness=1: digit 3 shows "2" (1011011).
- sum=255 -> digits 2,1,0 = "2","5","5". Then rst_n=0 mid-conversion -> FSM IDLE, BCD=000, and reconversion after release shows 255 again.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the matchstick game display slice.
//
// Contents:
//   SEG_*         seven-segment glyphs, active high, bit order {g,f,e,d,c,b,a}.
//   DIGIT_IDX_W   width of the scan digit index (four digits).
//   conv_state_t  state encoding of the sequential binary-to-BCD converter.
//   hex_glyph()   maps a 4-bit value to its hex glyph.
package game_pkg;

  localparam int DIGIT_IDX_W = 2;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_E_ERR = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  function automatic logic [6:0] hex_glyph(input logic [3:0] value);
    logic [6:0] glyph;
    unique case (value)
      4'h0:    glyph = SEG_0;
      4'h1:    glyph = SEG_1;
      4'h2:    glyph = SEG_2;
      4'h3:    glyph = SEG_3;
      4'h4:    glyph = SEG_4;
      4'h5:    glyph = SEG_5;
      4'h6:    glyph = SEG_6;
      4'h7:    glyph = SEG_7;
      4'h8:    glyph = SEG_8;
      4'h9:    glyph = SEG_9;
      4'hA:    glyph = SEG_A;
      4'hB:    glyph = SEG_B;
      4'hC:    glyph = SEG_C;
      4'hD:    glyph = SEG_D;
      4'hE:    glyph = SEG_E;
      default: glyph = SEG_F;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/bin8_to_bcd3_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3).
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous reset, active low
//   start     request a new conversion of 'value' (sampled in IDLE)
//   value     8-bit unsigned operand
//   captured  operand latched by the most recent capture
//   result    BCD scratch {hundreds,tens,units}; valid while done=1
//   done      one-cycle pulse when result holds a finished conversion
//
// A conversion takes capture + 8 shift cycles + one DONE cycle.
module bin8_to_bcd3_seq
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  value,
  output logic [7:0]  captured,
  output logic [11:0] result,
  output logic        done
);

  conv_state_t state, state_next;
  logic [11:0] scratch;
  logic [11:0] scratch_adj;
  logic [7:0]  operand;
  logic [2:0]  iter;
  logic        primed;
  logic        load;

  // The first IDLE cycle after reset always captures, even if value
  // happens to equal the cleared captured register.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start || !primed) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (iter == 3'd7) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < 3; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5) scratch_adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scratch  <= '0;
      operand  <= '0;
      iter     <= '0;
      captured <= '0;
      primed   <= 1'b0;
    end else if (load) begin
      captured <= value;
      operand  <= value;
      scratch  <= '0;
      iter     <= '0;
      primed   <= 1'b1;
    end else if (state == SHIFT) begin
      {scratch, operand} <= {scratch_adj, operand} << 1;
      iter               <= iter + 3'd1;
    end
  end

  assign result = scratch;

endmodule

// File: rtl/game_status_display.sv
// Display stage of the matchstick game: shows the turn on digit 3 and the
// remaining sum in decimal on digits 2..0 of a multiplexed 4-digit panel.
// An illegal move replaces the turn with "E".
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active low
//   turn         current player number (hex glyph on digit 3)
//   sum          remaining matchsticks, unsigned
//   correctness  1 = last move legal, 0 = illegal move pending
//   grounds      one-hot digit enable, digit 3 leftmost
//   display      segments {g,f,e,d,c,b,a}, active high
//
// Parameters: SCAN_DIV (cycles per digit), BLINK_DIV (error blink half-period).
// Build option: define ERR_BLINK_EN to blink the "E" while correctness=0.
module game_status_display
  import game_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] turn,
  input  logic [7:0] sum,
  input  logic       correctness,
  output logic [3:0] grounds,
  output logic [6:0] display
);

  localparam int SCAN_W = $clog2(SCAN_DIV);

  logic [SCAN_W-1:0]      scan_cnt;
  logic                   scan_tick;
  logic [DIGIT_IDX_W-1:0] digit_idx;
  logic [DIGIT_IDX_W-1:0] idx_next;
  logic [7:0]             captured;
  logic [11:0]            conv_result;
  logic                   conv_done;
  logic [11:0]            bcd;
  logic                   blink_on;
  logic [6:0]             glyph3;
  logic [6:0]             glyph_mux;

  bin8_to_bcd3_seq u_conv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (sum != captured),
    .value    (sum),
    .captured (captured),
    .result   (conv_result),
    .done     (conv_done)
  );

  // The BCD register only changes on a finished conversion, so the panel
  // never shows a half-converted value.
  always_ff @(posedge clk) begin
    if (!rst_n)         bcd <= '0;
    else if (conv_done) bcd <= conv_result;
  end

`ifdef ERR_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_DIV);
  logic [BLINK_W-1:0] blink_cnt;

  // Blink restarts in the visible phase whenever the error clears.
  always_ff @(posedge clk) begin
    if (!rst_n || correctness) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end
`else
  // Steady "E"; BLINK_DIV is still referenced so both builds share one
  // parameter set (it is always >= 2, so this is constant 1).
  assign blink_on = (BLINK_DIV > 0);
`endif

  assign glyph3    = correctness ? hex_glyph(turn) : (blink_on ? SEG_E_ERR : SEG_BLANK);
  assign scan_tick = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign idx_next  = scan_tick ? digit_idx + DIGIT_IDX_W'(1) : digit_idx;

  // Content is chosen from the index the scan is moving to, so the
  // registered segments and grounds switch together.
  always_comb begin
    glyph_mux = SEG_BLANK;
    unique case (idx_next)
      2'd0: glyph_mux = hex_glyph(bcd[3:0]);
      2'd1: glyph_mux = (bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0) ? SEG_BLANK : hex_glyph(bcd[7:4]);
      2'd2: glyph_mux = (bcd[11:8] == 4'd0) ? SEG_BLANK : hex_glyph(bcd[11:8]);
      default: glyph_mux = glyph3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      grounds   <= 4'b0001;
      display   <= SEG_BLANK;
    end else begin
      scan_cnt  <= scan_tick ? '0 : scan_cnt + SCAN_W'(1);
      digit_idx <= idx_next;
      grounds   <= 4'b0001 << idx_next;
      display   <= glyph_mux;
    end
  end

endmodule

// File: tb/tb_game_status_display.sv
// Self-checking bench for game_status_display with SCAN_DIV=4, BLINK_DIV=8.
// Directed vectors; expected glyphs and BCD values are hand-computed.
// Works with or without ERR_BLINK_EN defined.
module tb_game_status_display;
  import game_pkg::*;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] turn;
  logic [7:0] sum;
  logic       correctness;
  logic [3:0] grounds;
  logic [6:0] display;

  int check_count = 0;
  int fail_count  = 0;

  game_status_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .turn        (turn),
    .sum         (sum),
    .correctness (correctness),
    .grounds     (grounds),
    .display     (display)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] t, input logic [7:0] s, input logic c);
    turn        = t;
    sum         = s;
    correctness = c;
  endtask

  task automatic checkOutput(input string tag, input logic [11:0] actual, input logic [11:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Watch one full scan rotation and compare what each digit showed.
  task automatic scanDigits(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    logic [7:0] seen [4];
    for (int i = 0; i < 4; i++) seen[i] = 8'hFF;
    for (int c = 0; c < 4 * SCAN_DIV + 2; c++) begin
      tick(1);
      case (grounds)
        4'b0001: seen[0] = {1'b0, display};
        4'b0010: seen[1] = {1'b0, display};
        4'b0100: seen[2] = {1'b0, display};
        4'b1000: seen[3] = {1'b0, display};
        default: ;
      endcase
    end
    checkOutput({tag, "_d3"}, {4'h0, seen[3]}, {5'h0, e3});
    checkOutput({tag, "_d2"}, {4'h0, seen[2]}, {5'h0, e2});
    checkOutput({tag, "_d1"}, {4'h0, seen[1]}, {5'h0, e1});
    checkOutput({tag, "_d0"}, {4'h0, seen[0]}, {5'h0, e0});
  endtask

  logic [6:0] blink_exp_off;

  initial begin
`ifdef ERR_BLINK_EN
    blink_exp_off = 7'b0000000;
`else
    blink_exp_off = 7'b1111001;
`endif

    // Reset and scan stepping
    rst_n = 1'b0;
    applyStimulus(4'd1, 8'd0, 1'b1);
    tick(3);
    checkOutput("rst_grounds", {8'h0, grounds}, 12'h001);
    checkOutput("rst_display", {5'h0, display}, 12'h000);
    rst_n = 1'b1;
    checkOutput("post_rst_display", {5'h0, display}, 12'h000);
    tick(1);
    checkOutput("first_digit0", {5'h0, display}, 12'h03F);
    tick(2);
    checkOutput("scan_r3", {8'h0, grounds}, 12'h001);
    tick(1);
    checkOutput("scan_r4", {8'h0, grounds}, 12'h002);
    tick(4);
    checkOutput("scan_r8", {8'h0, grounds}, 12'h004);
    tick(4);
    checkOutput("scan_r12", {8'h0, grounds}, 12'h008);
    tick(4);
    checkOutput("scan_r16", {8'h0, grounds}, 12'h001);

    // Basic sums
    applyStimulus(4'd1, 8'd100, 1'b1);
    tick(12);
    scanDigits("sum100", 7'b0000110, 7'b0000110, 7'b0111111, 7'b0111111);
    applyStimulus(4'd1, 8'd7, 1'b1);
    tick(12);
    scanDigits("sum7", 7'b0000110, 7'b0000000, 7'b0000000, 7'b0000111);
    applyStimulus(4'd1, 8'd0, 1'b1);
    tick(12);
    scanDigits("sum0", 7'b0000110, 7'b0000000, 7'b0000000, 7'b0111111);

    // Change mid-conversion: 100 finishes first, then 93 is recaptured
    applyStimulus(4'd1, 8'd100, 1'b1);
    tick(3);
    applyStimulus(4'd1, 8'd93, 1'b1);
    tick(6);
    checkOutput("bcd_c9", dut.bcd, 12'h000);
    tick(1);
    checkOutput("bcd_c10", dut.bcd, 12'h100);
    tick(9);
    checkOutput("bcd_c19", dut.bcd, 12'h100);
    tick(1);
    checkOutput("bcd_c20", dut.bcd, 12'h093);
    scanDigits("sum93", 7'b0000110, 7'b0000000, 7'b1101111, 7'b1001111);

    // Illegal move with turn 2
    applyStimulus(4'd2, 8'd93, 1'b0);
    tick(1);
    checkOutput("err_e1", {5'h0, dut.glyph3}, 12'h079);
    tick(6);
    checkOutput("err_e7", {5'h0, dut.glyph3}, 12'h079);
    tick(1);
    checkOutput("err_e8", {5'h0, dut.glyph3}, {5'h0, blink_exp_off});
    tick(7);
    checkOutput("err_e15", {5'h0, dut.glyph3}, {5'h0, blink_exp_off});
    tick(1);
    checkOutput("err_e16", {5'h0, dut.glyph3}, 12'h079);
`ifndef ERR_BLINK_EN
    scanDigits("err", 7'b1111001, 7'b0000000, 7'b1101111, 7'b1001111);
`endif
    applyStimulus(4'd2, 8'd93, 1'b1);
    tick(1);
    checkOutput("err_clear", {5'h0, dut.glyph3}, 12'h05B);
    scanDigits("turn2", 7'b1011011, 7'b0000000, 7'b1101111, 7'b1001111);

    // sum=255 with reset in the middle of its conversion
    applyStimulus(4'd2, 8'd255, 1'b1);
    tick(4);
    rst_n = 1'b0;
    tick(2);
    checkOutput("midrst_state", {10'h0, dut.u_conv.state}, {10'h0, IDLE});
    checkOutput("midrst_bcd", dut.bcd, 12'h000);
    checkOutput("midrst_display", {5'h0, display}, 12'h000);
    rst_n = 1'b1;
    tick(1);
    checkOutput("recap_state", {10'h0, dut.u_conv.state}, {10'h0, SHIFT});
    tick(9);
    checkOutput("recap_bcd", dut.bcd, 12'h255);
    scanDigits("sum255", 7'b1011011, 7'b1011011, 7'b1101101, 7'b1101101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", check_count, fail_count);
    $finish;
  end

endmodule
